// File: rtl/ctrl_pkg.sv
// Shared decode constants, control bundle and FSM state type for decode_ctrl_pipe.
// Optional illegal-instruction trapping is selected in the top by ILLEGAL_TRAP_EN.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_BEQ    = 5'd10;
    localparam logic [4:0] ALU_BLT    = 5'd11;
    localparam logic [4:0] ALU_BLTU   = 5'd12;
    localparam logic [4:0] ALU_LUI    = 5'd13;
    localparam logic [4:0] ALU_MUL    = 5'd14;
    localparam logic [4:0] ALU_MULH   = 5'd15;
    localparam logic [4:0] ALU_MULHSU = 5'd16;
    localparam logic [4:0] ALU_MULHU  = 5'd17;
    localparam logic [4:0] ALU_DIV    = 5'd18;
    localparam logic [4:0] ALU_DIVU   = 5'd19;
    localparam logic [4:0] ALU_REM    = 5'd20;
    localparam logic [4:0] ALU_REMU   = 5'd21;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] res_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       adder_src;
        logic [2:0] imm_src;
        logic [4:0] alu_code;
    } ctrl_t;

    typedef enum logic {
        IDLE,
        MC_BUSY
    } state_t;

    // Integer ALU op for OP / OP-IMM; alt selects sub or sra.
    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32IM decoder: instruction fields -> control bundle,
// multi-cycle flag, latency select (0 = MUL, 1 = DIV) and illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic       is_mc,
    output logic       lat_div,
    output logic       illegal
);

    logic legal;

    always_comb begin
        ctrl    = '0;
        is_mc   = 1'b0;
        lat_div = 1'b0;
        legal   = 1'b0;
        case (op)
            OP_LOAD: if (funct3 != 3'b011 && funct3[2:1] != 2'b11) begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.res_src   = 2'b01;
                ctrl.alu_src_b = 1'b1;
            end
            OP_STORE: if (!funct3[2] && funct3 != 3'b011) begin
                legal          = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.imm_src   = IMM_S;
            end
            OP_IMM: if ((funct3 == 3'b001) ? (funct7 == F7_BASE) :
                        (funct3 == 3'b101) ? (funct7 == F7_BASE || funct7 == F7_ALT) : 1'b1) begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                // immediates share funct7 bits, so only shifts may select the alternate op
                ctrl.alu_code  = alu_base(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OP_OP: begin
                if (funct7 == F7_MUL) begin
                    legal          = 1'b1;
                    is_mc          = 1'b1;
                    lat_div        = funct3[2];
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_code  = (funct3[2] ? ALU_DIV : ALU_MUL) + {3'b000, funct3[1:0]};
                end else if (funct7 == F7_BASE ||
                             (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    legal          = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_code  = alu_base(funct3, funct7[5]);
                end
            end
            OP_LUI: begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.imm_src   = IMM_U;
                ctrl.alu_code  = ALU_LUI;
            end
            OP_AUIPC: begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.imm_src   = IMM_U;
            end
            OP_BRANCH: if (funct3[2:1] != 2'b01) begin
                legal         = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.imm_src  = IMM_B;
                ctrl.alu_code = !funct3[2] ? ALU_BEQ : (funct3[1] ? ALU_BLTU : ALU_BLT);
            end
            OP_JALR: if (funct3 == 3'b000) begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.res_src   = 2'b10;
                ctrl.jump      = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.adder_src = 1'b1;
                ctrl.imm_src   = IMM_I;
            end
            OP_JAL: begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.res_src   = 2'b10;
                ctrl.jump      = 1'b1;
                ctrl.imm_src   = IMM_J;
            end
            default: ;
        endcase
        illegal = !legal;
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// D/E control pipeline register with multi-cycle MUL/DIV sequencing.
// Define ILLEGAL_TRAP_EN to carry undecodable instructions into E flagged illegal_e.
module decode_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 5,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_d,
    input  logic                  valid_d,
    input  logic                  stall_e,
    input  logic                  flush_e,
    output logic                  reg_write_e,
    output logic [1:0]            res_src_e,
    output logic                  mem_write_e,
    output logic                  jump_e,
    output logic                  branch_e,
    output logic                  alu_src_a_e,
    output logic                  alu_src_b_e,
    output logic                  adder_src_e,
    output logic [2:0]            imm_src_e,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  valid_e,
    output logic                  illegal_e,
    output logic                  mc_start_e,
    output logic                  busy_d
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'((DIV_LATENCY > 1) ? DIV_LATENCY - 2 : 0);

    ctrl_t            ctrl_d, ctrl_q;
    logic             dec_mc, dec_div, dec_ill;
    logic             accept, hold, load, multi;
    logic             valid_q, mc_start_q;
    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    ctrl_decode u_decode (
        .op      (instr_d[6:0]),
        .funct3  (instr_d[14:12]),
        .funct7  (instr_d[31:25]),
        .ctrl    (ctrl_d),
        .is_mc   (dec_mc),
        .lat_div (dec_div),
        .illegal (dec_ill)
    );

    assign hold  = stall_e || (state_q == MC_BUSY);
    assign load  = !flush_e && !hold && accept;
    assign multi = dec_div ? (DIV_LATENCY > 1) : (MUL_LATENCY > 1);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: if (load && dec_mc && multi) begin
                state_n = MC_BUSY;
                cnt_n   = dec_div ? DIV_CNT : MUL_CNT;
            end
            MC_BUSY: begin
                if (flush_e) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_q == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            mc_start_q <= 1'b0;
        end else if (flush_e) begin
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            mc_start_q <= 1'b0;
        end else if (hold) begin
            mc_start_q <= 1'b0;
        end else if (!accept) begin
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            mc_start_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            valid_q    <= 1'b1;
            mc_start_q <= dec_mc;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    assign accept = valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (flush_e) begin
            illegal_q <= 1'b0;
        end else if (!hold) begin
            illegal_q <= valid_d && dec_ill;
        end
    end

    assign illegal_e = illegal_q;
`else
    assign accept    = valid_d && !dec_ill;
    assign illegal_e = 1'b0;
`endif

    assign reg_write_e   = ctrl_q.reg_write;
    assign res_src_e     = ctrl_q.res_src;
    assign mem_write_e   = ctrl_q.mem_write;
    assign jump_e        = ctrl_q.jump;
    assign branch_e      = ctrl_q.branch;
    assign alu_src_a_e   = ctrl_q.alu_src_a;
    assign alu_src_b_e   = ctrl_q.alu_src_b;
    assign adder_src_e   = ctrl_q.adder_src;
    assign imm_src_e     = ctrl_q.imm_src;
    assign alu_control_e = ALU_CTRL_W'(ctrl_q.alu_code);
    assign valid_e       = valid_q;
    assign mc_start_e    = mc_start_q;
    assign busy_d        = (state_q == MC_BUSY);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed scoreboard bench for decode_ctrl_pipe (MUL_LATENCY = 1, DIV_LATENCY = 8).
module tb_decode_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       mc_start;
        logic       busy;
        logic       reg_write;
        logic [1:0] res_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       adder_src;
        logic [2:0] imm_src;
        logic [4:0] alu;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_d = '0;
    logic        valid_d = 1'b0;
    logic        stall_e = 1'b0;
    logic        flush_e = 1'b0;
    logic        reg_write_e, mem_write_e, jump_e, branch_e;
    logic        alu_src_a_e, alu_src_b_e, adder_src_e;
    logic [1:0]  res_src_e;
    logic [2:0]  imm_src_e;
    logic [4:0]  alu_control_e;
    logic        valid_e, illegal_e, mc_start_e, busy_d;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    decode_ctrl_pipe #(
        .ALU_CTRL_W  (5),
        .MUL_LATENCY (1),
        .DIV_LATENCY (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_d       (instr_d),
        .valid_d       (valid_d),
        .stall_e       (stall_e),
        .flush_e       (flush_e),
        .reg_write_e   (reg_write_e),
        .res_src_e     (res_src_e),
        .mem_write_e   (mem_write_e),
        .jump_e        (jump_e),
        .branch_e      (branch_e),
        .alu_src_a_e   (alu_src_a_e),
        .alu_src_b_e   (alu_src_b_e),
        .adder_src_e   (adder_src_e),
        .imm_src_e     (imm_src_e),
        .alu_control_e (alu_control_e),
        .valid_e       (valid_e),
        .illegal_e     (illegal_e),
        .mc_start_e    (mc_start_e),
        .busy_d        (busy_d)
    );

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
        return {imm, 5'd2, f3, 5'd1, op};
    endfunction

    function automatic obs_t ex(input logic rw, input logic [1:0] rs, input logic mw, input logic j,
                                input logic br, input logic sa, input logic sb, input logic ads,
                                input logic [2:0] imm, input logic [4:0] alu);
        obs_t o;
        o = '0;
        o.valid = 1'b1; o.reg_write = rw; o.res_src = rs; o.mem_write = mw; o.jump = j;
        o.branch = br; o.alu_src_a = sa; o.alu_src_b = sb; o.adder_src = ads;
        o.imm_src = imm; o.alu = alu;
        return o;
    endfunction

    function automatic obs_t mc(input obs_t o, input logic s, input logic b);
        obs_t r;
        r = o;
        r.mc_start = s;
        r.busy = b;
        return r;
    endfunction

    task automatic check_out();
        obs_t  got, want;
        string tag;
        got = {valid_e, illegal_e, mc_start_e, busy_d, reg_write_e, res_src_e, mem_write_e,
               jump_e, branch_e, alu_src_a_e, alu_src_b_e, adder_src_e, imm_src_e, alu_control_e};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected none", got);
        end else begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (got === want) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                        input obs_t want, input string tag);
        instr_d = ins; valid_d = v; stall_e = st; flush_e = fl;
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_now(input obs_t want, input string tag);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ADD, SUB, ADDI_HI, SRA, LUI, AUIPC, LW, SW, BNE, BLTU, JAL, JALR;
        logic [31:0] MUL, DIV, DIVU, ILL_OP, ILL_F7;
        obs_t        zero, e_add, e_div, e_divu, e_jal, e_ill;

        ADD     = r_ins(7'b0000000, 3'b000);
        SUB     = r_ins(7'b0100000, 3'b000);
        SRA     = r_ins(7'b0100000, 3'b101);
        MUL     = r_ins(7'b0000001, 3'b000);
        DIV     = r_ins(7'b0000001, 3'b100);
        DIVU    = r_ins(7'b0000001, 3'b101);
        ILL_F7  = r_ins(7'b0000010, 3'b000);
        ADDI_HI = i_ins(12'h400, 3'b000, 7'b0010011);
        LW      = i_ins(12'h004, 3'b010, 7'b0000011);
        SW      = i_ins(12'h000, 3'b010, 7'b0100011);
        BNE     = i_ins(12'h000, 3'b001, 7'b1100011);
        BLTU    = i_ins(12'h000, 3'b110, 7'b1100011);
        JALR    = i_ins(12'h000, 3'b000, 7'b1100111);
        LUI     = {20'h12345, 5'd1, 7'b0110111};
        AUIPC   = {20'h00001, 5'd1, 7'b0010111};
        JAL     = {20'h00010, 5'd1, 7'b1101111};
        ILL_OP  = 32'h0000_007F;

        zero   = '0;
        e_add  = ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0);
        e_div  = ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd18);
        e_divu = ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd19);
        e_jal  = ex(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 5'd0);
`ifdef ILLEGAL_TRAP_EN
        e_ill = '0;
        e_ill.valid = 1'b1;
        e_ill.illegal = 1'b1;
`else
        e_ill = '0;
`endif

        instr_d = ADD; valid_d = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_now(zero, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(ADD,     1'b1, 1'b0, 1'b0, e_add, "add");
        step(SUB,     1'b1, 1'b0, 1'b0, ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd1), "sub");
        step(ADDI_HI, 1'b1, 1'b0, 1'b0, ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd0), "addi_f7hi");
        step(SRA,     1'b1, 1'b0, 1'b0, ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd7), "sra");
        step(LUI,     1'b1, 1'b0, 1'b0, ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 5'd13), "lui");
        step(AUIPC,   1'b1, 1'b0, 1'b0, ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 5'd0), "auipc");
        step(LW,      1'b1, 1'b0, 1'b0, ex(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd0), "lw");
        step(SW,      1'b1, 1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 5'd0), "sw");
        step(BNE,     1'b1, 1'b0, 1'b0, ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd10), "bne");
        step(BLTU,    1'b1, 1'b0, 1'b0, ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd12), "bltu");
        step(JALR,    1'b1, 1'b0, 1'b0, ex(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 5'd0), "jalr");
        step(ADD,     1'b0, 1'b0, 1'b0, zero, "not_valid");

        // div: E held 8 cycles, busy_d high for the first 7, next op on the 9th edge
        step(DIV, 1'b1, 1'b0, 1'b0, mc(e_div, 1'b1, 1'b1), "div_start");
        for (int i = 0; i < 6; i++) step(ADD, 1'b1, 1'b0, 1'b0, mc(e_div, 1'b0, 1'b1), "div_busy");
        step(ADD, 1'b1, 1'b0, 1'b0, e_div, "div_last");
        step(ADD, 1'b1, 1'b0, 1'b0, e_add, "div_next");

        step(MUL, 1'b1, 1'b0, 1'b0, mc(ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd14), 1'b1, 1'b0), "mul_lat1");
        step(ADD, 1'b1, 1'b0, 1'b0, e_add, "mul_next");

        step(DIVU, 1'b1, 1'b0, 1'b0, mc(e_divu, 1'b1, 1'b1), "divu_start");
        step(ADD,  1'b1, 1'b0, 1'b0, mc(e_divu, 1'b0, 1'b1), "divu_busy");
        step(ADD,  1'b1, 1'b0, 1'b0, mc(e_divu, 1'b0, 1'b1), "divu_busy");
        step(ADD,  1'b1, 1'b0, 1'b1, zero, "divu_flush");
        step(ADD,  1'b1, 1'b0, 1'b0, e_add, "after_flush");

        step(JAL, 1'b1, 1'b1, 1'b1, zero, "stall_flush_jal");
        step(JAL, 1'b1, 1'b0, 1'b0, e_jal, "jal");
        step(ADD, 1'b1, 1'b1, 1'b0, e_jal, "stall_hold1");
        step(ADD, 1'b1, 1'b1, 1'b0, e_jal, "stall_hold2");
        step(ADD, 1'b1, 1'b0, 1'b0, e_add, "stall_release");
        step(DIV, 1'b1, 1'b1, 1'b0, e_add, "stall_mop");
        step(ADD, 1'b1, 1'b0, 1'b0, e_add, "stall_mop_nostart");

        step(ILL_OP, 1'b1, 1'b0, 1'b0, e_ill, "illegal_op");
        step(ILL_F7, 1'b1, 1'b0, 1'b0, e_ill, "illegal_f7");

        // asynchronous reset in the middle of a divide
        step(DIV, 1'b1, 1'b0, 1'b0, mc(e_div, 1'b1, 1'b1), "div2_start");
        step(ADD, 1'b1, 1'b0, 1'b0, mc(e_div, 1'b0, 1'b1), "div2_busy");
        #2 rst_n = 1'b0;
        #1 check_now(zero, "reset_mid_op");
        @(negedge clk);
        rst_n = 1'b1;
        step(ADD, 1'b1, 1'b0, 1'b0, e_add, "add_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
